// File: rtl/led_pattern_gen.sv
// LED pattern generator: count, walking one, bounce and PWM breathing
// patterns stepped by a programmable prescaler.
module led_pattern_gen #(
    parameter int NUM_LEDS  = 8,
    parameter int DIV_WIDTH = 24,
    parameter int PWM_BITS  = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [1:0]           mode,
    input  logic [DIV_WIDTH-1:0] step_div,
    output logic [NUM_LEDS-1:0]  leds,
    output logic                 tick
);

    localparam int PW = (NUM_LEDS > 2) ? $clog2(NUM_LEDS) : 1;

    typedef enum logic [1:0] {
        M_COUNT   = 2'd0,
        M_WALK    = 2'd1,
        M_BOUNCE  = 2'd2,
        M_BREATHE = 2'd3
    } mode_t;

    localparam logic [NUM_LEDS-1:0] ONE  = NUM_LEDS'(1);
    localparam logic [PW-1:0]       TOP  = PW'(NUM_LEDS - 1);
    localparam logic [PW-1:0]       NTOP = PW'(NUM_LEDS - 2);

    mode_t                mode_q;
    logic [DIV_WIDTH-1:0] div_cnt, div_n;
    logic [NUM_LEDS-1:0]  cnt, cnt_n;
    logic [NUM_LEDS-1:0]  walk, walk_n;
    logic [PW-1:0]        pos, pos_n;
    logic                 dir_dn, dir_dn_n;
    logic [PWM_BITS-1:0]  duty, duty_n;
    logic                 ddir_dn, ddir_dn_n;
    logic [PWM_BITS-1:0]  pwm_cnt;
    logic [NUM_LEDS-1:0]  leds_n;
    logic                 chg, adv;

    assign chg = (mode != mode_q);
    assign adv = (div_cnt >= step_div) && !chg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mode_q  <= M_COUNT;
            div_cnt <= '0;
            cnt     <= '0;
            walk    <= ONE;
            pos     <= '0;
            dir_dn  <= 1'b0;
            duty    <= '0;
            ddir_dn <= 1'b0;
            pwm_cnt <= '0;
            leds    <= '0;
            tick    <= 1'b0;
        end else begin
            mode_q  <= mode_t'(mode);
            div_cnt <= div_n;
            cnt     <= cnt_n;
            walk    <= walk_n;
            pos     <= pos_n;
            dir_dn  <= dir_dn_n;
            duty    <= duty_n;
            ddir_dn <= ddir_dn_n;
            pwm_cnt <= pwm_cnt + PWM_BITS'(1);
            leds    <= leds_n;
            tick    <= adv;
        end
    end

    // A mode change re-inits only the newly selected pattern.
    always_comb begin
        div_n     = div_cnt + DIV_WIDTH'(1);
        cnt_n     = cnt;
        walk_n    = walk;
        pos_n     = pos;
        dir_dn_n  = dir_dn;
        duty_n    = duty;
        ddir_dn_n = ddir_dn;
        if (chg) begin
            div_n = '0;
            unique case (mode_t'(mode))
                M_COUNT:   cnt_n = '0;
                M_WALK:    walk_n = ONE;
                M_BOUNCE: begin
                    pos_n    = '0;
                    dir_dn_n = 1'b0;
                end
                M_BREATHE: begin
                    duty_n    = '0;
                    ddir_dn_n = 1'b0;
                end
            endcase
        end else if (adv) begin
            div_n = '0;
            unique case (mode_q)
                M_COUNT:   cnt_n = cnt + NUM_LEDS'(1);
                M_WALK:    walk_n = {walk[NUM_LEDS-2:0], walk[NUM_LEDS-1]};
                M_BOUNCE: begin
                    if (!dir_dn) begin
                        if (pos == TOP) begin
                            dir_dn_n = 1'b1;
                            pos_n    = NTOP;
                        end else begin
                            pos_n = pos + PW'(1);
                        end
                    end else begin
                        if (pos == '0) begin
                            dir_dn_n = 1'b0;
                            pos_n    = PW'(1);
                        end else begin
                            pos_n = pos - PW'(1);
                        end
                    end
                end
                M_BREATHE: begin
                    if (!ddir_dn) begin
                        if (duty == '1) begin
                            ddir_dn_n = 1'b1;
                            duty_n    = duty - PWM_BITS'(1);
                        end else begin
                            duty_n = duty + PWM_BITS'(1);
                        end
                    end else begin
                        if (duty == '0) begin
                            ddir_dn_n = 1'b0;
                            duty_n    = duty + PWM_BITS'(1);
                        end else begin
                            duty_n = duty - PWM_BITS'(1);
                        end
                    end
                end
            endcase
        end
    end

    always_comb begin
        leds_n = '0;
        unique case (mode_q)
            M_COUNT:   leds_n = cnt;
            M_WALK:    leds_n = walk;
            M_BOUNCE:  leds_n = ONE << pos;
            M_BREATHE: leds_n = {NUM_LEDS{pwm_cnt < duty}};
        endcase
    end

endmodule

// File: tb/tb_led_pattern_gen.sv
// Directed bench for led_pattern_gen: vector table plus
// hand-written sequences for breathing, mode switch, divider and reset.
module tb_led_pattern_gen;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [1:0]  mode = 2'd0;
    logic [23:0] step_div = 24'd3;
    logic [7:0]  leds;
    logic        tick;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    led_pattern_gen #(
        .NUM_LEDS(8),
        .DIV_WIDTH(24),
        .PWM_BITS(4)
    ) dut (
        .clk(clk),
        .rst(rst),
        .mode(mode),
        .step_div(step_div),
        .leds(leds),
        .tick(tick)
    );

    typedef struct {
        logic [1:0]  m;
        logic [23:0] sd;
        int          n;
        logic [7:0]  l;
        logic        t;
        string       name;
    } vec_t;

    vec_t vt[$];

    task automatic add(input logic [1:0] m, input logic [23:0] sd, input int n,
                       input logic [7:0] l, input logic t, input string name);
        vec_t v;
        v.m = m; v.sd = sd; v.n = n; v.l = l; v.t = t; v.name = name;
        vt.push_back(v);
    endtask

    task automatic edge_n(input int n);
        repeat (n) begin
            @(posedge clk);
            @(negedge clk);
        end
    endtask

    task automatic chk(input string nm, input logic [7:0] l, input logic t);
        checks++;
        if (leds !== l || tick !== t) begin
            errors++;
            $display("FAIL %s: leds=%h tick=%b required leds=%h tick=%b",
                     nm, leds, tick, l, t);
        end
    endtask

    task automatic chk_int(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d required %0d", nm, act, exp);
        end
    endtask

    task automatic wait_tick(input int budget, input string nm);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < budget; i++) begin
            edge_n(1);
            if (tick === 1'b1) begin
                seen = 1'b1;
                break;
            end
        end
        chk_int(nm, int'(seen), 1);
    endtask

    initial begin
        int ones;
        int uni;
        int exp;

        // count, step_div 3: one step every 4 edges
        add(0, 3, 4,    8'h00, 1, "cnt_step1_tick");
        add(0, 3, 1,    8'h01, 0, "cnt_01");
        add(0, 3, 3,    8'h01, 1, "cnt_step2_tick");
        add(0, 3, 1,    8'h02, 0, "cnt_02");
        add(0, 3, 4,    8'h03, 0, "cnt_03");
        add(0, 3, 1008, 8'hff, 0, "cnt_ff");
        add(0, 3, 3,    8'hff, 1, "cnt_step256_tick");
        add(0, 3, 1,    8'h00, 0, "cnt_wrap");
        // walk, step_div 0
        add(1, 0, 1,    8'h00, 0, "walk_chg_edge");
        add(1, 0, 1,    8'h01, 1, "walk_init");
        add(1, 0, 1,    8'h02, 1, "walk_02");
        add(1, 0, 6,    8'h80, 1, "walk_80");
        add(1, 0, 1,    8'h01, 1, "walk_wrap");
        // bounce, step_div 1
        add(2, 1, 1,    8'h02, 0, "bounce_chg_edge");
        add(2, 1, 1,    8'h01, 0, "bounce_init");
        add(2, 1, 1,    8'h01, 1, "bounce_step1_tick");
        add(2, 1, 1,    8'h02, 0, "bounce_02");
        add(2, 1, 12,   8'h80, 0, "bounce_top");
        add(2, 1, 1,    8'h80, 1, "bounce_turn_tick");
        add(2, 1, 1,    8'h40, 0, "bounce_40");
        add(2, 1, 12,   8'h01, 0, "bounce_bottom");
        add(2, 1, 2,    8'h02, 0, "bounce_period");
        // breathe, step_div 63: change edge only
        add(3, 63, 1,   8'h02, 0, "breathe_chg_edge");

        @(negedge clk);
        @(negedge clk);
        chk("reset", 8'h00, 1'b0);
        rst = 1'b0;

        foreach (vt[i]) begin
            mode     = vt[i].m;
            step_div = vt[i].sd;
            edge_n(vt[i].n);
            chk(vt[i].name, vt[i].l, vt[i].t);
        end

        // breathing: duty ramps 0..15 then back, measured over 16 PWM slots
        for (int k = 1; k <= 30; k++) begin
            wait_tick(100, "breathe_tick");
            edge_n(1);
            ones = 0;
            uni  = 1;
            for (int j = 0; j < 16; j++) begin
                edge_n(1);
                if (leds[0] === 1'b1) ones++;
                if (leds !== {8{leds[0]}}) uni = 0;
            end
            exp = (k <= 15) ? k : 30 - k;
            chk_int($sformatf("breathe_duty_step%0d", k), ones, exp);
            chk_int($sformatf("breathe_uniform_step%0d", k), uni, 1);
        end

        // switch 0 -> 1 while cnt = 5
        mode     = 2'd0;
        step_div = 24'd3;
        edge_n(1);
        repeat (5) wait_tick(10, "sw_cnt_tick");
        chk("sw_cnt5", 8'h04, 1'b1);
        mode = 2'd1;
        edge_n(1);
        chk("sw_chg_edge", 8'h05, 1'b0);
        edge_n(1);
        chk("sw_walk_init", 8'h01, 1'b0);
        edge_n(2);
        chk("sw_no_early_tick", 8'h01, 1'b0);
        edge_n(1);
        chk("sw_first_tick", 8'h01, 1'b1);
        edge_n(1);
        chk("sw_walk_02", 8'h02, 1'b0);

        // lowering step_div below the running count forces a step
        step_div = 24'd100;
        wait_tick(200, "div100_tick");
        edge_n(50);
        chk_int("div50_no_tick", int'(tick), 0);
        step_div = 24'd2;
        edge_n(1);
        chk_int("div_lowered_step", int'(tick), 1);
        edge_n(1);
        chk_int("div_lowered_after", int'(tick), 0);

        // asynchronous reset mid-bounce at pos 5
        mode     = 2'd2;
        step_div = 24'd1;
        edge_n(1);
        repeat (5) wait_tick(10, "rst_bounce_tick");
        chk("pre_reset_pos5", 8'h10, 1'b1);
        #2 rst = 1'b1;
        #1 chk("async_reset", 8'h00, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        edge_n(1);
        chk("rel_chg_edge", 8'h00, 1'b0);
        edge_n(1);
        chk("rel_init", 8'h01, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
